// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : riscv_pkg
//  Description : Shared RV64I encoding constants for the instruction encoder.
//                Holds the ld/sd/branch opcodes, the request-kind enum and the
//                signed immediate ranges of the 12-bit and 13-bit formats.
//  Revision    : 1.0 - initial release
// ============================================================================
package riscv_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef enum logic [1:0] {
        K_LD  = 2'd0,
        K_SD  = 2'd1,
        K_BR  = 2'd2,
        K_ILL = 2'd3
    } kind_e;

    // I/S-type immediates: 12-bit signed
    localparam logic signed [63:0] IMM12_MIN = -64'sd2048;
    localparam logic signed [63:0] IMM12_MAX =  64'sd2047;
    // B-type immediates: 13-bit signed, always even
    localparam logic signed [63:0] IMM13_MIN = -64'sd4096;
    localparam logic signed [63:0] IMM13_MAX =  64'sd4094;

endpackage
`default_nettype wire

// File: rtl/inst_encoder_if.sv
`default_nettype none
// ============================================================================
//  Module      : inst_encoder_if
//  Description : Request and output valid/ready streams of the encoder.
//                Request : in_valid/in_ready + kind, funct3, rd, rs1, rs2, imm
//                Output  : out_valid/out_ready + out_inst, out_addr
//                slave modport = encoder side, master modport = driver side.
//  Revision    : 1.0 - initial release
// ============================================================================
interface inst_encoder_if
    import riscv_pkg::*;
#(
    parameter int ADDR_W = 32
);
    logic              in_valid;
    logic              in_ready;
    kind_e             in_kind;
    logic [2:0]        in_funct3;
    logic [4:0]        in_rd;
    logic [4:0]        in_rs1;
    logic [4:0]        in_rs2;
    logic [63:0]       in_imm;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_inst;
    logic [ADDR_W-1:0] out_addr;

    modport slave (
        input  in_valid, in_kind, in_funct3, in_rd, in_rs1, in_rs2, in_imm,
        output in_ready,
        output out_valid, out_inst, out_addr,
        input  out_ready
    );

    modport master (
        output in_valid, in_kind, in_funct3, in_rd, in_rs1, in_rs2, in_imm,
        input  in_ready,
        input  out_valid, out_inst, out_addr,
        output out_ready
    );
endinterface
`default_nettype wire

// File: rtl/inst_encoder_imm_pack.sv
`default_nettype none
// ============================================================================
//  Module      : imm_pack
//  Description : Combinational range check and bit scatter of a 64-bit signed
//                immediate into an RV64I ld / sd / branch instruction word.
//                Inputs : kind, funct3, rd, rs1, rs2, imm[63:0]
//                Outputs: inst[31:0], legal
//  Revision    : 1.0 - initial release
// ============================================================================
module imm_pack
    import riscv_pkg::*;
(
    input  kind_e       kind,
    input  logic [2:0]  funct3,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [63:0] imm,
    output logic [31:0] inst,
    output logic        legal
);

    logic signed [63:0] w_imm_s;
    logic               w_fits12;
    logic               w_fits13;

    // Full 64-bit signed compare: any stray high bit makes the value out of range
    assign w_imm_s  = imm;
    assign w_fits12 = (w_imm_s >= IMM12_MIN) && (w_imm_s <= IMM12_MAX);
    assign w_fits13 = (w_imm_s >= IMM13_MIN) && (w_imm_s <= IMM13_MAX) && !imm[0];

    always_comb begin
        inst  = '0;
        legal = 1'b0;
        case (kind)
            K_LD: begin
                inst  = {imm[11:0], rs1, funct3, rd, OP_LOAD};
                legal = w_fits12;
            end
            K_SD: begin
                inst  = {imm[11:5], rs2, rs1, funct3, imm[4:0], OP_STORE};
                legal = w_fits12;
            end
            K_BR: begin
                inst  = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], OP_BRANCH};
                legal = w_fits13;
            end
            default: begin
                inst  = '0;
                legal = 1'b0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/inst_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : inst_encoder
//  Description : Encodes ld / sd / branch requests into RV64I words and emits
//                them with an auto-incrementing byte address. Illegal
//                requests are consumed, dropped and counted.
//                Ports: clk, reset_n (async, active low), start (sync
//                restart), bus (inst_encoder_if.slave), err (sticky),
//                reject_cnt (saturating).
//  Revision    : 1.0 - initial release
// ============================================================================
module inst_encoder
    import riscv_pkg::*;
#(
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter int                CNT_W     = 8
)(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    inst_encoder_if.slave     bus,
    output logic              err,
    output logic [CNT_W-1:0]  reject_cnt
);

    logic [31:0]       w_inst;
    logic              w_legal;
    logic              w_ready;
    logic              w_accept;

    logic              r_out_valid;
    logic [31:0]       r_out_inst;
    logic [ADDR_W-1:0] r_out_addr;
    logic [ADDR_W-1:0] r_next_addr;
    logic              r_err;
    logic [CNT_W-1:0]  r_reject_cnt;

    imm_pack u_imm_pack (
        .kind   (bus.in_kind),
        .funct3 (bus.in_funct3),
        .rd     (bus.in_rd),
        .rs1    (bus.in_rs1),
        .rs2    (bus.in_rs2),
        .imm    (bus.in_imm),
        .inst   (w_inst),
        .legal  (w_legal)
    );

    // Ready whenever the output slot is empty or being drained this cycle;
    // held low during start so a request is never consumed by a flush.
    assign w_ready  = !start && (!r_out_valid || bus.out_ready);
    assign w_accept = bus.in_valid && w_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_out_valid  <= 1'b0;
            r_out_inst   <= '0;
            r_out_addr   <= BASE_ADDR;
            r_next_addr  <= BASE_ADDR;
            r_err        <= 1'b0;
            r_reject_cnt <= '0;
        end else if (start) begin
            r_out_valid  <= 1'b0;
            r_next_addr  <= BASE_ADDR;
            r_err        <= 1'b0;
            r_reject_cnt <= '0;
        end else if (w_accept && w_legal) begin
            r_out_valid <= 1'b1;
            r_out_inst  <= w_inst;
            r_out_addr  <= r_next_addr;
            r_next_addr <= r_next_addr + ADDR_W'(4);
        end else begin
            if (w_accept) begin
                r_err <= 1'b1;
                if (r_reject_cnt != '1) begin
                    r_reject_cnt <= r_reject_cnt + CNT_W'(1);
                end
            end
            if (bus.out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign bus.in_ready  = w_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_inst  = r_out_inst;
    assign bus.out_addr  = r_out_addr;
    assign err           = r_err;
    assign reject_cnt    = r_reject_cnt;

endmodule
`default_nettype wire

// File: tb/tb_inst_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_inst_encoder
//  Description : Directed self-checking bench for inst_encoder. A 32-bit
//                address instance covers encoding, legality, back-pressure,
//                start and async reset; a 4-bit address instance covers
//                address wrap.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_inst_encoder;
    import riscv_pkg::*;

    logic       clk;
    logic       reset_n;
    logic       start;
    logic       err;
    logic [7:0] reject_cnt;
    logic       err4;
    logic [7:0] reject_cnt4;

    int n_cmp  = 0;
    int n_fail = 0;

    inst_encoder_if #(.ADDR_W(32)) bus  ();
    inst_encoder_if #(.ADDR_W(4))  bus4 ();

    inst_encoder #(.ADDR_W(32), .BASE_ADDR(32'h0), .CNT_W(8)) u_dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .bus        (bus),
        .err        (err),
        .reject_cnt (reject_cnt)
    );

    inst_encoder #(.ADDR_W(4), .BASE_ADDR(4'h0), .CNT_W(8)) u_dut4 (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .bus        (bus4),
        .err        (err4),
        .reject_cnt (reject_cnt4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input kind_e k, input logic [2:0] f3, input logic [4:0] rd,
                         input logic [4:0] rs1, input logic [4:0] rs2, input logic [63:0] imm);
        bus.in_valid  = 1'b1;
        bus.in_kind   = k;
        bus.in_funct3 = f3;
        bus.in_rd     = rd;
        bus.in_rs1    = rs1;
        bus.in_rs2    = rs2;
        bus.in_imm    = imm;
    endtask

    task automatic idle;
        bus.in_valid = 1'b0;
    endtask

    task automatic test_reset;
        #1;
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", bus.out_valid); end
        n_cmp++; if (bus.out_inst !== 32'h0) begin n_fail++; $display("FAIL reset_inst: got %h want 0", bus.out_inst); end
        n_cmp++; if (bus.out_addr !== 32'h0) begin n_fail++; $display("FAIL reset_addr: got %h want 0", bus.out_addr); end
        n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", err); end
        n_cmp++; if (reject_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d want 0", reject_cnt); end
        #11;
        reset_n = 1'b1;
    endtask

    task automatic test_back_to_back;
        drive(K_LD, 3'd3, 5'd5, 5'd2, 5'd0, -64'sd8);
        #1;
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready0: got %b want 1", bus.in_ready); end
        step;
        n_cmp++; if (bus.out_inst !== 32'hFF813283) begin n_fail++; $display("FAIL ld_inst: got %h want ff813283", bus.out_inst); end
        n_cmp++; if (bus.out_addr !== 32'd0) begin n_fail++; $display("FAIL ld_addr: got %h want 0", bus.out_addr); end
        n_cmp++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL ld_valid: got %b want 1", bus.out_valid); end
        drive(K_SD, 3'd3, 5'd0, 5'd2, 5'd6, 64'd16);
        #1;
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready1: got %b want 1", bus.in_ready); end
        step;
        n_cmp++; if (bus.out_inst !== 32'h00613823) begin n_fail++; $display("FAIL sd_inst: got %h want 00613823", bus.out_inst); end
        n_cmp++; if (bus.out_addr !== 32'd4) begin n_fail++; $display("FAIL sd_addr: got %h want 4", bus.out_addr); end
        idle;
        step;
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL drain_valid: got %b want 0", bus.out_valid); end
    endtask

    task automatic test_branch;
        drive(K_BR, 3'd0, 5'd0, 5'd1, 5'd2, -64'sd4);
        step;
        n_cmp++; if (bus.out_inst !== 32'hFE208EE3) begin n_fail++; $display("FAIL br_inst: got %h want fe208ee3", bus.out_inst); end
        n_cmp++; if (bus.out_addr !== 32'd8) begin n_fail++; $display("FAIL br_addr: got %h want 8", bus.out_addr); end
        drive(K_BR, 3'd0, 5'd0, 5'd1, 5'd2, 64'd3);
        step;
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL odd_valid: got %b want 0", bus.out_valid); end
        n_cmp++; if (err !== 1'b1) begin n_fail++; $display("FAIL odd_err: got %b want 1", err); end
        n_cmp++; if (reject_cnt !== 8'd1) begin n_fail++; $display("FAIL odd_cnt: got %0d want 1", reject_cnt); end
        drive(K_LD, 3'd3, 5'd1, 5'd1, 5'd0, 64'd2047);
        step;
        n_cmp++; if (bus.out_inst !== 32'h7FF0B083) begin n_fail++; $display("FAIL ld2047_inst: got %h want 7ff0b083", bus.out_inst); end
        n_cmp++; if (bus.out_addr !== 32'd12) begin n_fail++; $display("FAIL ld2047_addr: got %h want c", bus.out_addr); end
        idle;
        step;
    endtask

    task automatic test_range;
        kind_e       ill_k   [5] = '{K_LD, K_LD, K_BR, K_ILL, K_LD};
        logic [63:0] ill_imm [5] = '{64'd2048, -64'sd2049, 64'd4096, 64'd0, 64'h0000_0001_0000_0000};
        for (int i = 0; i < 5; i++) begin
            drive(ill_k[i], 3'd0, 5'd1, 5'd1, 5'd1, ill_imm[i]);
            step;
        end
        n_cmp++; if (reject_cnt !== 8'd6) begin n_fail++; $display("FAIL range_cnt: got %0d want 6", reject_cnt); end
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL range_valid: got %b want 0", bus.out_valid); end
        drive(K_SD, 3'd7, 5'd0, 5'd31, 5'd31, -64'sd2048);
        step;
        n_cmp++; if (bus.out_inst !== 32'h81FFF023) begin n_fail++; $display("FAIL sdmin_inst: got %h want 81fff023", bus.out_inst); end
        n_cmp++; if (bus.out_addr !== 32'd16) begin n_fail++; $display("FAIL sdmin_addr: got %h want 10", bus.out_addr); end
        drive(K_BR, 3'd1, 5'd0, 5'd0, 5'd0, 64'd4094);
        step;
        n_cmp++; if (bus.out_inst !== 32'h7E001FE3) begin n_fail++; $display("FAIL brmax_inst: got %h want 7e001fe3", bus.out_inst); end
        n_cmp++; if (bus.out_addr !== 32'd20) begin n_fail++; $display("FAIL brmax_addr: got %h want 14", bus.out_addr); end
        drive(K_BR, 3'd5, 5'd0, 5'd3, 5'd4, -64'sd4096);
        step;
        n_cmp++; if (bus.out_inst !== 32'h8041D063) begin n_fail++; $display("FAIL brmin_inst: got %h want 8041d063", bus.out_inst); end
        n_cmp++; if (bus.out_addr !== 32'd24) begin n_fail++; $display("FAIL brmin_addr: got %h want 18", bus.out_addr); end
        idle;
        step;
    endtask

    task automatic test_backpressure;
        drive(K_LD, 3'd3, 5'd2, 5'd1, 5'd0, 64'd4);
        bus.out_ready = 1'b0;
        step;
        drive(K_SD, 3'd2, 5'd0, 5'd1, 5'd3, 64'd8);
        for (int i = 0; i < 5; i++) begin
            n_cmp++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready[%0d]: got %b want 0", i, bus.in_ready); end
            n_cmp++; if (bus.out_valid !== 1'b1 || bus.out_inst !== 32'h0040B103 || bus.out_addr !== 32'd28) begin
                n_fail++; $display("FAIL bp_hold[%0d]: got v=%b %h @%h want v=1 0040b103 @1c", i, bus.out_valid, bus.out_inst, bus.out_addr);
            end
            step;
        end
        bus.out_ready = 1'b1;
        #1;
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_ready: got %b want 1", bus.in_ready); end
        step;
        n_cmp++; if (bus.out_inst !== 32'h0030A423) begin n_fail++; $display("FAIL bp_next_inst: got %h want 0030a423", bus.out_inst); end
        n_cmp++; if (bus.out_addr !== 32'd32) begin n_fail++; $display("FAIL bp_next_addr: got %h want 20", bus.out_addr); end
        idle;
        step;
    endtask

    task automatic test_start;
        drive(K_LD, 3'd3, 5'd2, 5'd1, 5'd0, 64'd4);
        step;
        n_cmp++; if (bus.out_addr !== 32'd36) begin n_fail++; $display("FAIL st_pre_addr: got %h want 24", bus.out_addr); end
        n_cmp++; if (err !== 1'b1) begin n_fail++; $display("FAIL st_pre_err: got %b want 1", err); end
        drive(K_SD, 3'd2, 5'd0, 5'd1, 5'd3, 64'd8);
        start = 1'b1;
        #1;
        n_cmp++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL st_ready: got %b want 0", bus.in_ready); end
        step;
        start = 1'b0;
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL st_valid: got %b want 0", bus.out_valid); end
        n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL st_err: got %b want 0", err); end
        n_cmp++; if (reject_cnt !== 8'd0) begin n_fail++; $display("FAIL st_cnt: got %0d want 0", reject_cnt); end
        step;
        n_cmp++; if (bus.out_inst !== 32'h0030A423) begin n_fail++; $display("FAIL st_next_inst: got %h want 0030a423", bus.out_inst); end
        n_cmp++; if (bus.out_addr !== 32'd0) begin n_fail++; $display("FAIL st_next_addr: got %h want 0", bus.out_addr); end
        idle;
        step;
    endtask

    task automatic test_async_reset;
        drive(K_ILL, 3'd0, 5'd0, 5'd0, 5'd0, 64'd0);
        step;
        drive(K_LD, 3'd3, 5'd2, 5'd1, 5'd0, 64'd4);
        step;
        n_cmp++; if (bus.out_valid !== 1'b1 || bus.out_addr !== 32'd4 || err !== 1'b1) begin
            n_fail++; $display("FAIL ar_pre: got v=%b @%h err=%b want v=1 @4 err=1", bus.out_valid, bus.out_addr, err);
        end
        #2;
        reset_n = 1'b0;
        #1;
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL ar_valid: got %b want 0", bus.out_valid); end
        n_cmp++; if (bus.out_inst !== 32'h0) begin n_fail++; $display("FAIL ar_inst: got %h want 0", bus.out_inst); end
        n_cmp++; if (bus.out_addr !== 32'h0) begin n_fail++; $display("FAIL ar_addr: got %h want 0", bus.out_addr); end
        n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL ar_err: got %b want 0", err); end
        n_cmp++; if (reject_cnt !== 8'd0) begin n_fail++; $display("FAIL ar_cnt: got %0d want 0", reject_cnt); end
        idle;
        #2;
        reset_n = 1'b1;
        step;
    endtask

    task automatic test_wrap;
        logic [3:0] exp_addr [5] = '{4'd0, 4'd4, 4'd8, 4'd12, 4'd0};
        bus4.in_valid  = 1'b1;
        bus4.in_kind   = K_LD;
        bus4.in_funct3 = 3'd3;
        bus4.in_rd     = 5'd2;
        bus4.in_rs1    = 5'd1;
        bus4.in_rs2    = 5'd0;
        bus4.in_imm    = 64'd4;
        for (int i = 0; i < 5; i++) begin
            step;
            n_cmp++; if (bus4.out_valid !== 1'b1 || bus4.out_addr !== exp_addr[i]) begin
                n_fail++; $display("FAIL wrap_addr[%0d]: got v=%b @%h want v=1 @%h", i, bus4.out_valid, bus4.out_addr, exp_addr[i]);
            end
        end
        n_cmp++; if (bus4.out_inst !== 32'h0040B103) begin n_fail++; $display("FAIL wrap_inst: got %h want 0040b103", bus4.out_inst); end
        bus4.in_valid = 1'b0;
        step;
    endtask

    initial begin
        reset_n        = 1'b0;
        start          = 1'b0;
        bus.in_valid   = 1'b0;
        bus.in_kind    = K_LD;
        bus.in_funct3  = '0;
        bus.in_rd      = '0;
        bus.in_rs1     = '0;
        bus.in_rs2     = '0;
        bus.in_imm     = '0;
        bus.out_ready  = 1'b1;
        bus4.in_valid  = 1'b0;
        bus4.in_kind   = K_LD;
        bus4.in_funct3 = '0;
        bus4.in_rd     = '0;
        bus4.in_rs1    = '0;
        bus4.in_rs2    = '0;
        bus4.in_imm    = '0;
        bus4.out_ready = 1'b1;

        test_reset;
        test_back_to_back;
        test_branch;
        test_range;
        test_backpressure;
        test_start;
        test_async_reset;
        test_wrap;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
